led_pattern_engine: RTL and testbench
=====================================

Name: led_pattern_engine

Overview:
- Parametrised successor to the 8-LED pattern generator: N-LED width, programmable step period, one-shot mode, step/cycle-done strobes.
- Steps through one of eight selectable light patterns, advancing one frame per step tick.
- Sits between the board clock and the LED bank.
- Pattern changes land cleanly on step boundaries with pattern-state reload.

Parameters:
- WIDTH, 8, number of LEDs; even, 4..16.
- DIV_W, 16, width of the step-period counter.
- LFSR_SEED, 16'hACE1, nonzero seed of the 16-bit sparkle LFSR.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ena  in  1  block enable; 0 blanks LEDs and freezes all state
- pause  in  1  1 freezes all state and holds led_out
- pat_sel  in  3  requested pattern, sampled only on step ticks
- period  in  DIV_W  step period minus one, in clk cycles
- oneshot  in  1  1 halts after one full pattern cycle
- led_out  out  WIDTH  registered LED drive
- step  out  1  one-cycle pulse on the cycle led_out updates
- cycle_done  out  1  one-cycle pulse when the last frame of a sequence is emitted
- busy  out  1  1 while in RUN

Behaviour:
- Reset (rst=1 at clk edge) clears everything:
  - led_out=0; step=0; cycle_done=0; busy=0.
  - Tick counter cnt=0; frame index idx=0; pattern register pat=0.
  - LFSR=LFSR_SEED; FSM=IDLE.
- Run condition: run = ena & ~pause.
- Tick generator:
  - When run=1: if cnt>=period then cnt<=0 and tick=1, else cnt<=cnt+1.
  - period=0 gives a tick every cycle.
  - A period change applies immediately; if cnt already exceeds the new period, tick on the next run cycle.
  - When run=0, cnt holds.
- Freeze rules:
  - pause=1: all state and led_out hold; step and cycle_done = 0.
  - ena=0: all state holds, led_out<=0, strobes 0. On re-enable, the next tick emits the next frame; the frozen frame is not re-shown.
  - pause and ena=0 together: ena rule applies.
- FSM:
  - IDLE: on tick, pat<=pat_sel, emit frame 0, idx<=1, go to RUN.
  - RUN: on tick, if pat_sel!=pat then pat<=pat_sel, reload LFSR, emit frame 0, idx<=1. Otherwise emit frame idx, and idx<=idx+1, wrapping to 0 after the last frame L-1.
  - HALT: led_out holds the last frame; busy=0. A tick with pat_sel!=pat reloads exactly as in RUN and goes to RUN. oneshot=0 on a tick goes to RUN and emits frame 0.
- Strobe and one-shot rules:
  - step=1 for one cycle on every tick in which led_out is written with a frame.
  - cycle_done=1 on the tick that emits frame L-1.
  - If oneshot=1 at that tick, go to HALT.
  - A pattern change on that same tick wins: frame 0 of the new pattern, no cycle_done, no HALT.
- Patterns (H=WIDTH/2; frame k, length L):
  - 0 scan: single bit bouncing bit0 up to bit WIDTH-1 and back. L=2*WIDTH-2; frame k = bit k for k<WIDTH, else bit 2*WIDTH-2-k.
  - 1 walking pair: 2'b11 at position p, p bouncing 0..WIDTH-2..0. L=2*WIDTH-4.
  - 2 expand/contract:
    - Frames k=0..H-1: bits H-1-k..H+k set.
    - Then H-1 contracting frames mirroring the expand, then one all-off frame.
    - L=2*H. W=8 sequence: 18,3C,7E,FF,7E,3C,18,00.
  - 3 blink: all-ones, then zero. L=2.
  - 4 alternate: bit pattern 1010.. (0xAA at W=8), then its complement. L=2.
  - 5 marquee: low 3 bits set, rotated left k places. L=WIDTH.
  - 6 sparkle:
    - Output = LFSR[WIDTH-1:0], then LFSR advances.
    - Fibonacci LFSR, taps 16,14,13,11; shift left, feedback into bit0.
    - L treated as infinite: no cycle_done, never halts.
  - 7 off: all zero. L=1; cycle_done on every tick.
- Widths: idx sized for the max L (2*WIDTH-2); all shifts stay within WIDTH bits.

Test Plan:
- WIDTH=8, period=0, pat_sel=0, oneshot=0, release rst → led_out after the first 15 ticks: 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01. cycle_done on the 14th tick; the 15th tick restarts at 01.
- period=3, pat_sel=2 → step every 4th clk; led_out 18,3C,7E,FF,7E,3C,18,00; cycle_done with 00; busy=1 throughout.
- pat_sel=5, oneshot=1, period=0 → 07,0E,1C,38,70,E0,C1,83, then HALT. busy=0; led_out stays 83 for 20 cycles; no further step.
- Pattern 4 running, pause=1 for 10 cycles → led_out, cnt and strobes frozen. Switch pat_sel to 3 mid-pause, release → next tick emits FF.
- Pattern 0 at frame 08, ena=0 → led_out 00 next cycle. ena=1 → next tick emits 10. Assert rst mid-sequence → all outputs 0 next cycle, FSM in IDLE.
- pat_sel=6 → first frame = seed low byte E1. Change to 7 on the same tick as the wrap of pattern 2 → 00 emitted, cycle_done=0.

Source files
------------

// File: rtl/led_pattern_engine.sv
// led_pattern_engine
// Steps an N-LED bank through one of eight light patterns, one frame per step
// tick. The step tick comes from a programmable divider, and pattern changes
// take effect on tick boundaries.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous reset, active-high
//   ena        in   block enable; 0 blanks the LEDs and freezes all state
//   pause      in   1 freezes all state and holds led_out
//   pat_sel    in   requested pattern (0..7), sampled only on step ticks
//   period     in   step period minus one, in clk cycles
//   oneshot    in   1 halts after one full pattern cycle
//   led_out    out  registered LED drive
//   step       out  one-cycle pulse on the cycle led_out takes a new frame
//   cycle_done out  one-cycle pulse when the last frame of a sequence is shown
//   busy       out  1 while the sequencer is in RUN
module led_pattern_engine #(
  parameter int          WIDTH     = 8,
  parameter int          DIV_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pause,
  input  logic [2:0]       pat_sel,
  input  logic [DIV_W-1:0] period,
  input  logic             oneshot,
  output logic [WIDTH-1:0] led_out,
  output logic             step,
  output logic             cycle_done,
  output logic             busy
);

  localparam int               MAX_LEN  = 2 * WIDTH - 2;
  localparam int               IDX_W    = $clog2(MAX_LEN);
  localparam int               HALF     = WIDTH / 2;
  localparam logic [2:0]       SPARKLE  = 3'd6;
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAIR_W   = WIDTH'(3);
  localparam logic [WIDTH-1:0] TRIPLE_W = WIDTH'(7);
  localparam logic [WIDTH-1:0] ALT      = {HALF{2'b10}};

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [2:0]       pat, pat_next;
  logic [15:0]      lfsr, lfsr_next;
  logic [WIDTH-1:0] led_next;
  logic             step_next, done_next;
  logic             tick, load, restart, advance, last_frame;
  logic [2:0]       src_pat;
  logic [IDX_W-1:0] src_idx;
  logic [15:0]      src_lfsr;

  // Sequence length per pattern; sparkle has no length and is handled apart.
  function automatic int pat_len(input logic [2:0] p);
    case (p)
      3'd0:       return 2 * WIDTH - 2;
      3'd1:       return 2 * WIDTH - 4;
      3'd2, 3'd5: return WIDTH;
      3'd3, 3'd4: return 2;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [2:0] p,
                                                input logic [IDX_W-1:0] k);
    if (int'(k) + 1 >= pat_len(p)) return '0;
    return k + IDX_ONE;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Frame k of pattern p. The expand/contract pattern folds the second half
  // back onto the first via a mirrored index j; the final frame gets j = -1,
  // which yields an empty band.
  function automatic logic [WIDTH-1:0] frame_of(input logic [2:0]       p,
                                                input logic [IDX_W-1:0] k_in,
                                                input logic [15:0]      l);
    int k, j, n, lo;
    logic [WIDTH-1:0] f;
    k = int'(k_in);
    f = '0;
    case (p)
      3'd0: f = ONE_W << ((k < WIDTH) ? k : 2 * WIDTH - 2 - k);
      3'd1: f = PAIR_W << ((k < WIDTH - 1) ? k : 2 * WIDTH - 4 - k);
      3'd2: begin
        j  = (k < HALF) ? k : 2 * HALF - 2 - k;
        n  = 2 * j + 2;
        lo = HALF - 1 - j;
        f  = (ALL_ONES >> (WIDTH - n)) << lo;
      end
      3'd3: f = (k == 0) ? ALL_ONES : '0;
      3'd4: f = (k == 0) ? ALT : ~ALT;
      3'd5: f = (TRIPLE_W << k) | (TRIPLE_W >> (WIDTH - k));
      3'd6: f = l[WIDTH-1:0];
      default: f = '0;
    endcase
    return f;
  endfunction

  // Next-state logic. Every tick resolves to one of three actions: load a
  // new pattern (from IDLE, or on a pattern change), restart the current
  // pattern from HALT, or advance one frame. Only an advance that lands on
  // the last frame raises cycle_done; a load or restart never does.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    pat_next   = pat;
    lfsr_next  = lfsr;
    led_next   = led_out;
    step_next  = 1'b0;
    done_next  = 1'b0;
    tick       = 1'b0;
    load       = 1'b0;
    restart    = 1'b0;
    advance    = 1'b0;
    src_pat    = pat;
    src_idx    = idx;
    src_lfsr   = lfsr;
    last_frame = (int'(idx) == pat_len(pat) - 1);

    if (ena && !pause) begin
      if (cnt >= period) begin
        cnt_next = '0;
        tick     = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end

    if (tick) begin
      case (state)
        RUN: begin
          if (pat_sel != pat) load = 1'b1;
          else                advance = 1'b1;
        end
        HALT: begin
          if (pat_sel != pat) load = 1'b1;
          else if (!oneshot)  restart = 1'b1;
        end
        default: load = 1'b1;
      endcase
    end

    if (load) begin
      src_pat  = pat_sel;
      src_idx  = '0;
      src_lfsr = LFSR_SEED;
    end else if (restart) begin
      src_idx = '0;
    end

    if (load || restart || advance) begin
      led_next   = frame_of(src_pat, src_idx, src_lfsr);
      step_next  = 1'b1;
      pat_next   = src_pat;
      state_next = RUN;
      if (src_pat == SPARKLE) begin
        lfsr_next = lfsr_step(src_lfsr);
      end else begin
        lfsr_next = src_lfsr;
        idx_next  = next_idx(src_pat, src_idx);
      end
      if (advance && src_pat != SPARKLE && last_frame) begin
        done_next = 1'b1;
        if (oneshot) state_next = HALT;
      end
    end

    if (!ena) led_next = '0;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      pat        <= '0;
      lfsr       <= LFSR_SEED;
      led_out    <= '0;
      step       <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      pat        <= pat_next;
      lfsr       <= lfsr_next;
      led_out    <= led_next;
      step       <= step_next;
      cycle_done <= done_next;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine
// Self-checking bench for led_pattern_engine (WIDTH=8). A reference model
// built from precomputed frame tables queues the expected frame for every
// step and the expected led_out/busy for every cycle. A monitor pops both
// queues on the falling edge and compares them with the design's outputs.
module tb_led_pattern_engine;

  localparam int          WIDTH = 8;
  localparam int          DIV_W = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst, ena, pause, oneshot;
  logic [2:0]       pat_sel;
  logic [DIV_W-1:0] period;
  logic [WIDTH-1:0] led_out;
  logic             step, cycle_done, busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  typedef struct {int cyc; logic [WIDTH-1:0] led; logic done;} emit_t;
  typedef struct {logic [WIDTH-1:0] led; logic busy;} stat_t;

  emit_t            emit_q[$];
  stat_t            stat_q[$];
  logic [WIDTH-1:0] seen[$];

  logic [WIDTH-1:0] seq_tab [8][2*WIDTH];
  int               seq_len [8];

  int               m_cnt, m_k, m_mode, m_pat, m_lfsr;
  logic [WIDTH-1:0] m_led;

  led_pattern_engine #(.WIDTH(WIDTH), .DIV_W(DIV_W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pause(pause), .pat_sel(pat_sel),
    .period(period), .oneshot(oneshot), .led_out(led_out), .step(step),
    .cycle_done(cycle_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Frame tables written straight from the pattern definitions.
  task automatic build_tables();
    int h, full, alt, pos, lo, hi, j, v;
    h    = WIDTH / 2;
    full = (1 << WIDTH) - 1;
    alt  = 0;
    for (int i = 1; i < WIDTH; i += 2) alt |= (1 << i);
    seq_len = '{2*WIDTH-2, 2*WIDTH-4, 2*h, 2, 2, WIDTH, 0, 1};
    for (int p = 0; p < 8; p++)
      for (int k = 0; k < 2*WIDTH; k++) seq_tab[p][k] = '0;
    for (int k = 0; k < seq_len[0]; k++) begin
      pos = (k < WIDTH) ? k : 2*WIDTH-2-k;
      seq_tab[0][k] = WIDTH'(1 << pos);
    end
    for (int k = 0; k < seq_len[1]; k++) begin
      pos = (k <= WIDTH-2) ? k : 2*WIDTH-4-k;
      seq_tab[1][k] = WIDTH'(3 << pos);
    end
    for (int k = 0; k < seq_len[2]; k++) begin
      if (k < 2*h-1) begin
        j  = (k < h) ? k : 2*h-2-k;
        lo = h-1-j;
        hi = h+j;
        seq_tab[2][k] = WIDTH'((1 << (hi+1)) - (1 << lo));
      end
    end
    seq_tab[3][0] = WIDTH'(full);
    seq_tab[4][0] = WIDTH'(alt);
    seq_tab[4][1] = WIDTH'(full ^ alt);
    for (int k = 0; k < WIDTH; k++) begin
      v = 7 << k;
      seq_tab[5][k] = WIDTH'((v | (v >> WIDTH)) & full);
    end
  endtask

  function automatic int lfsr_model_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_show(input bit from_run);
    bit done;
    done = 1'b0;
    if (m_pat == 6) begin
      m_led  = m_lfsr[WIDTH-1:0];
      m_lfsr = lfsr_model_next(m_lfsr);
    end else begin
      m_led = seq_tab[m_pat][m_k];
      done  = from_run && (m_k == seq_len[m_pat] - 1);
      m_k   = (m_k + 1) % seq_len[m_pat];
    end
    m_mode = (done && oneshot) ? 2 : 1;
    emit_q.push_back('{cycle, m_led, done});
  endtask

  // Reference model: m_mode 0 = idle, 1 = running, 2 = halted.
  initial begin : model
    bit tick;
    build_tables();
    forever begin
      @(posedge clk);
      cycle++;
      if (rst) begin
        m_cnt = 0; m_k = 0; m_mode = 0; m_pat = 0; m_lfsr = SEED; m_led = '0;
      end else if (!ena) begin
        m_led = '0;
      end else if (!pause) begin
        tick  = (m_cnt >= int'(period));
        m_cnt = tick ? 0 : m_cnt + 1;
        if (tick) begin
          if (m_mode == 0 || int'(pat_sel) != m_pat) begin
            m_pat = int'(pat_sel); m_lfsr = SEED; m_k = 0;
            model_show(1'b0);
          end else if (m_mode == 2) begin
            if (!oneshot) begin
              m_k = 0;
              model_show(1'b0);
            end
          end else begin
            model_show(1'b1);
          end
        end
      end
      stat_q.push_back('{m_led, m_mode == 1});
    end
  end

  // Monitor: compares outputs against the queued expectations each cycle.
  initial begin : monitor
    emit_t e;
    stat_t s;
    logic  exp_step;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check_output("led_out", led_out, s.led);
        check_output("busy", busy, s.busy);
      end
      exp_step = (emit_q.size() > 0) && (emit_q[0].cyc == cycle);
      check_output("step", step, exp_step);
      if (exp_step) begin
        e = emit_q.pop_front();
        check_output("frame", led_out, e.led);
        check_output("cycle_done", cycle_done, e.done);
      end else begin
        check_output("cycle_done_idle", cycle_done, 1'b0);
      end
      if (step === 1'b1) seen.push_back(led_out);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic p,
                                input logic [2:0] sel, input logic [DIV_W-1:0] per,
                                input logic os);
    rst = r; ena = e; pause = p; pat_sel = sel; period = per; oneshot = os;
  endtask

  initial begin : stimulus
    logic [WIDTH-1:0] exp_scan [15];
    logic [WIDTH-1:0] exp_marq [8];
    logic [WIDTH-1:0] exp_exp  [8];
    bit found;
    exp_scan = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    exp_marq = '{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83};
    exp_exp  = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00};

    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    wait_cycles(3);
    check_output("reset_led", led_out, '0);
    check_output("reset_busy", busy, 1'b0);

    // Scan pattern from reset.
    seen.delete();
    rst = 1'b0;
    wait_cycles(16);
    if (seen.size() >= 15) begin
      for (int i = 0; i < 15; i++)
        check_output($sformatf("scan_%0d", i), seen[i], exp_scan[i]);
    end else begin
      check_output("scan_count", seen.size(), 15);
    end

    // Marquee in one-shot mode: eight frames, then halt.
    pat_sel = 3'd5; oneshot = 1'b1;
    seen.delete();
    wait_cycles(30);
    check_output("marq_count", seen.size(), 8);
    if (seen.size() >= 8)
      for (int i = 0; i < 8; i++)
        check_output($sformatf("marq_%0d", i), seen[i], exp_marq[i]);
    check_output("halt_led", led_out, 8'h83);
    check_output("halt_busy", busy, 1'b0);

    // Alternate pattern, pause with a pattern change part-way through.
    oneshot = 1'b0; pat_sel = 3'd4;
    wait_cycles(5);
    pause = 1'b1;
    wait_cycles(5);
    pat_sel = 3'd3;
    wait_cycles(5);
    seen.delete();
    pause = 1'b0;
    wait_cycles(3);
    check_output("pause_resume", (seen.size() > 0) ? seen[0] : 8'hxx, 8'hFF);

    // Scan, blanked at frame 08, then re-enabled.
    pat_sel = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      wait_cycles(1);
      found = (m_mode == 1 && m_pat == 0 && m_led == 8'h08);
    end
    check_output("reach_08", found, 1'b1);
    ena = 1'b0;
    wait_cycles(1);
    check_output("blank_led", led_out, 8'h00);
    wait_cycles(3);
    seen.delete();
    ena = 1'b1;
    wait_cycles(2);
    check_output("reenable", (seen.size() > 0) ? seen[0] : 8'hxx, 8'h10);
    rst = 1'b1;
    wait_cycles(1);
    check_output("midrst_led", led_out, 8'h00);
    check_output("midrst_busy", busy, 1'b0);
    check_output("midrst_step", step, 1'b0);

    // Expand/contract at period 3.
    seen.delete();
    rst = 1'b0; pat_sel = 3'd2; period = 16'd3;
    wait_cycles(40);
    if (seen.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        check_output($sformatf("expand_%0d", i), seen[i], exp_exp[i]);
    end else begin
      check_output("expand_count", seen.size(), 8);
    end

    // Sparkle starts from the seed.
    seen.delete();
    pat_sel = 3'd6; period = '0;
    wait_cycles(3);
    check_output("sparkle_first", (seen.size() > 0) ? seen[0] : 8'hxx, 8'hE1);

    // Switch to off exactly on the wrap tick of expand/contract.
    pat_sel = 3'd2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      wait_cycles(1);
      found = (m_mode == 1 && m_pat == 2 && m_k == 7);
    end
    check_output("reach_wrap", found, 1'b1);
    pat_sel = 3'd7;
    wait_cycles(1);
    check_output("wrap_chg_led", led_out, 8'h00);
    check_output("wrap_chg_step", step, 1'b1);
    check_output("wrap_chg_done", cycle_done, 1'b0);
    wait_cycles(4);

    // Randomized traffic against the model.
    for (int it = 0; it < 600; it++) begin
      apply_stimulus($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 6) == 0,
                     ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : pat_sel,
                     ($urandom_range(0, 4) == 0) ? DIV_W'($urandom_range(0, 9)) : period,
                     $urandom_range(0, 2) == 0);
      wait_cycles($urandom_range(1, 8));
    end

    apply_stimulus(1'b0, 1'b1, 1'b0, pat_sel, period, 1'b0);
    wait_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
